frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Parametrised single-bank SRAM arbiter and frame-buffer rotator for the video pipeline. Sits between N pixel clients (capture, filter, transform, display, …) and one ZBT SRAM bank. It arbitrates one access per cycle and maps each client's image-relative address into the frame buffer that client currently owns. It rotates buffer ownership on every frame boundary and returns read data to the requesting client through a tagged read-latency pipeline. One instance is used per SRAM bank.

## Interface
- NUM_CLIENTS, 4: number of clients; also the number of frame buffers in the bank.
- ADDR_W, 19: SRAM word-address width.
- DATA_W, 36: SRAM data width.
- IMAGE_LENGTH, 76800: words per frame buffer; buffer b starts at b*IMAGE_LENGTH.
- READ_LATENCY, 3: cycles from grant cycle to the cycle mem_rdata is valid; must be ≥1.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_flag  in  1  one-cycle pulse; rotate buffer ownership.
- req  in  NUM_CLIENTS  per-client access request; held until granted.
- wr  in  NUM_CLIENTS  per-client 1=write, 0=read; qualified by req.
- addr  in  NUM_CLIENTS*ADDR_W  per-client offset within its own buffer; client i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CLIENTS*DATA_W  per-client write data, packed the same way.
- grant  out  NUM_CLIENTS  combinational one-hot; access accepted this cycle.
- rvalid  out  NUM_CLIENTS  registered one-hot; rdata belongs to this client.
- rdata  out  DATA_W  registered read data.
- buf_sel  out  NUM_CLIENTS*$clog2(NUM_CLIENTS)  current buffer index per client.
- mem_addr  out  ADDR_W  registered SRAM address.
- mem_we  out  1  registered write enable, active-high.
- mem_wdata  out  DATA_W  registered SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data.

## Operation
- Ownership:
  - Reset sets buf_sel[i]=i.
  - On frame_flag: buf_sel[i] <= buf_sel[i-1] for i≥1, and buf_sel[0] <= buf_sel[NUM_CLIENTS-1]. Each buffer therefore advances to the next pipeline stage, and client 0 recycles the last stage's buffer.
  - Ownership is always a permutation, so no two clients share a buffer.
- Address mapping: physical address = buf_sel[i]*IMAGE_LENGTH + addr[i], computed at ADDR_W bits with overflow discarded. Offsets ≥ IMAGE_LENGTH are not checked.
- Arbitration: at most one grant per cycle, and only to a client with req=1. Default policy is fixed priority, lowest index wins. With no requests, grant=0 and mem_we=0.
- Granted write: mem_addr, mem_we=1 and mem_wdata are registered from the winner.
- Granted read: mem_we=0 and mem_addr is registered. The tag {valid, client id} enters a READ_LATENCY-deep shift register.
- Read return: when a valid tag reaches the head, mem_rdata is registered into rdata and rvalid[id] is set for one cycle. Otherwise rvalid=0 and rdata holds its last value.
- Back-to-back reads from any mix of clients are fully pipelined, with one return per cycle.
- A client may drop req before grant with no effect.

## Timing
- Reset values: grant=0, rvalid=0, rdata=0, mem_addr=0, mem_we=0, mem_wdata=0; read queue cleared; buf_sel[i]=i.
- Grant in cycle T. mem_addr/mem_we/mem_wdata are valid in T+1. For reads, rvalid/rdata are valid in T+READ_LATENCY+1.
- frame_flag in cycle T: accesses granted in T use the old mapping, and the new mapping applies from T+1. Reads in flight still return to their tagged client.
- reset together with frame_flag: reset wins.
- Reset during in-flight reads: all tags are dropped and no rvalid is produced.
- A requester may be starved under fixed priority; clients must tolerate this.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A last-grant pointer is reset to NUM_CLIENTS-1.
  - Priority starts at last+1, wrapping at NUM_CLIENTS.
  - The pointer updates only on a grant.
  - No client waits more than NUM_CLIENTS-1 cycles while holding req.
- Undefined: fixed priority as above.

## Test plan
- Reset, then client 2 reads offset 5 with no other requests:
  - grant=4'b0100 at T; mem_addr=2*76800+5=153605, mem_we=0 at T+1.
  - rvalid=4'b0100 at T+4, with rdata equal to the model SRAM contents.
- All four clients request every cycle, fixed priority: client 0 granted every cycle; others never granted. With ARB_ROUND_ROBIN_EN, grants cycle through 0,1,2,3,0…
- Client 1 issues a read in T and client 3 a read in T+1:
  - rvalid=4'b0010 at T+4 and 4'b1000 at T+5, each with correct data.
- Pulse frame_flag once: buf_sel goes from {3,2,1,0} (client 3…0) to {2,1,0,3}. A client 0 write at offset 0 then lands at address 3*76800=230400.
- Client 0 read granted in T, with frame_flag also in T: mem_addr uses buffer 0, and rvalid[0] still asserts at T+4.
- Client 3 read in flight, reset asserted at T+2: no rvalid at T+4; all outputs return to their reset values.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Single-bank SRAM arbiter: one access per cycle, per-client frame-buffer mapping, tagged read return.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module frame_buffer_arbiter #(
    parameter int  NUM_CLIENTS  = 4,
    parameter int  ADDR_W       = 19,
    parameter int  DATA_W       = 36,
    parameter int  IMAGE_LENGTH = 76800,
    parameter int  READ_LATENCY = 3,
    localparam int SEL_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_flag,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]        grant,
    output logic [NUM_CLIENTS-1:0]        rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic [NUM_CLIENTS*SEL_W-1:0]  buf_sel,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam logic [ADDR_W-1:0] IMG_LEN = ADDR_W'(IMAGE_LENGTH);

    logic [NUM_CLIENTS*SEL_W-1:0]  buf_sel_q, buf_sel_d;
    logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
    logic                          mem_we_q, mem_we_d;
    logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
    logic [READ_LATENCY-1:0]       tag_vld_q, tag_vld_d;
    logic [READ_LATENCY*SEL_W-1:0] tag_id_q, tag_id_d;
    logic [NUM_CLIENTS-1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0]             rdata_q, rdata_d;

    logic                          win_valid;
    logic [SEL_W-1:0]              win_id;
    logic [SEL_W-1:0]              win_sel;
    logic [ADDR_W-1:0]             phys_addr;
    logic [SEL_W-1:0]              head_id;

`ifdef ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] last_q, last_d;

    // Scan from the farthest offset down so the client just after last_q is written last and wins.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % NUM_CLIENTS]) begin
                win_valid = 1'b1;
                win_id    = SEL_W'((int'(last_q) + k) % NUM_CLIENTS);
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (win_valid) last_d = win_id;
    end

    always_ff @(posedge clock) begin
        if (reset) last_q <= SEL_W'(NUM_CLIENTS - 1);
        else       last_q <= last_d;
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_id    = SEL_W'(i);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (win_valid && !reset) grant[win_id] = 1'b1;
    end

    // Mapping uses the ownership in force this cycle; a frame_flag now only affects next cycle.
    always_comb begin
        win_sel   = buf_sel_q[int'(win_id)*SEL_W +: SEL_W];
        phys_addr = ADDR_W'(win_sel) * IMG_LEN + addr[int'(win_id)*ADDR_W +: ADDR_W];
    end

    always_comb begin
        buf_sel_d = buf_sel_q;
        if (frame_flag) begin
            buf_sel_d[0 +: SEL_W] = buf_sel_q[(NUM_CLIENTS-1)*SEL_W +: SEL_W];
            for (int i = 1; i < NUM_CLIENTS; i++)
                buf_sel_d[i*SEL_W +: SEL_W] = buf_sel_q[(i-1)*SEL_W +: SEL_W];
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (win_valid) begin
            mem_addr_d = phys_addr;
            mem_we_d   = wr[win_id];
            if (wr[win_id]) mem_wdata_d = wdata[int'(win_id)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        tag_vld_d             = tag_vld_q;
        tag_id_d              = tag_id_q;
        tag_vld_d[0]          = win_valid & ~wr[win_id];
        tag_id_d[0 +: SEL_W]  = win_id;
        for (int k = 1; k < READ_LATENCY; k++) begin
            tag_vld_d[k]               = tag_vld_q[k-1];
            tag_id_d[k*SEL_W +: SEL_W] = tag_id_q[(k-1)*SEL_W +: SEL_W];
        end
    end

    always_comb begin
        head_id  = tag_id_q[(READ_LATENCY-1)*SEL_W +: SEL_W];
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_vld_q[READ_LATENCY-1]) begin
            rvalid_d[head_id] = 1'b1;
            rdata_d           = mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLIENTS; i++)
                buf_sel_q[i*SEL_W +: SEL_W] <= SEL_W'(i);
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            buf_sel_q   <= buf_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign buf_sel   = buf_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_frame_buffer_arbiter;
    localparam int N     = 4;
    localparam int AW    = 19;
    localparam int DW    = 36;
    localparam int IL    = 76800;
    localparam int RL    = 3;
    localparam int SW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset, frame_flag;
    logic [N-1:0]  req, wr, grant, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [N*SW-1:0] buf_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_we;

    frame_buffer_arbiter #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .IMAGE_LENGTH(IL), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag), .req(req), .wr(wr),
        .addr(addr), .wdata(wdata), .grant(grant), .rvalid(rvalid), .rdata(rdata),
        .buf_sel(buf_sel), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a[18:1], a[17:0] ^ 18'h2A5A5};
    endfunction

    // SRAM model: address captured one edge after it is presented, data out RL cycles after grant.
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] rd_pipe [RL-1];
    bit            sram_rdy = 1'b0;
    always @(posedge clock) begin
        if (!sram_rdy) begin
            for (int a = 0; a < DEPTH; a++) sram[a] <= pat(AW'(a));
            sram_rdy <= 1'b1;
        end else begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            rd_pipe[0] <= sram[mem_addr];
            for (int k = 1; k < RL - 1; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign mem_rdata = rd_pipe[RL-2];

    typedef struct { int cyc; int id; logic [DW-1:0] data; } ret_t;

    int            n_chk = 0, n_fail = 0;
    int            cyc = 0;
    int            own [N];
    int            last_g = N - 1;
    int            last_win = -1;
    logic [DW-1:0] exp_mem [DEPTH];
    ret_t          rq [$];
    logic [AW-1:0] e_maddr;
    logic          e_mwe;
    logic [DW-1:0] e_mwdata, e_rdata;
    logic [N-1:0]  e_rvalid;
    bit            reg_chk = 1'b0;

    logic          d_rst, d_ff;
    logic [N-1:0]  d_req, d_wr;
    logic [N*AW-1:0] d_addr;
    logic [N*DW-1:0] d_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int            w;
        int            pa;
        int            tmp;
        logic [N-1:0]  eg;
        logic [N*SW-1:0] ebs;
        ret_t          r;
        @(negedge clock);
        reset = d_rst; frame_flag = d_ff; req = d_req; wr = d_wr; addr = d_addr; wdata = d_wdata;
        #1;
        e_rvalid = '0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            e_rvalid[rq[0].id] = 1'b1;
            e_rdata = rq[0].data;
            void'(rq.pop_front());
        end
        if (reg_chk) begin
            for (int i = 0; i < N; i++) ebs[i*SW +: SW] = SW'(own[i]);
            check("buf_sel", 64'(buf_sel), 64'(ebs));
            check("mem_we", 64'(mem_we), 64'(e_mwe));
            check("mem_addr", 64'(mem_addr), 64'(e_maddr));
            if (e_mwe) check("mem_wdata", 64'(mem_wdata), 64'(e_mwdata));
            check("rvalid", 64'(rvalid), 64'(e_rvalid));
            check("rdata", 64'(rdata), 64'(e_rdata));
        end
        w = -1;
        if (!d_rst) begin
`ifdef ARB_ROUND_ROBIN_EN
            for (int k = 1; k <= N; k++)
                if (w < 0 && d_req[(last_g + k) % N]) w = (last_g + k) % N;
`else
            for (int i = 0; i < N; i++)
                if (w < 0 && d_req[i]) w = i;
`endif
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("grant", 64'(grant), 64'(eg));
        last_win = w;
        if (d_rst) begin
            for (int i = 0; i < N; i++) own[i] = i;
            rq.delete();
            e_maddr = '0; e_mwe = 1'b0; e_mwdata = '0; e_rdata = '0;
            last_g  = N - 1;
            reg_chk = 1'b1;
        end else begin
            if (w >= 0) begin
                pa = (own[w] * IL + int'(d_addr[w*AW +: AW])) % DEPTH;
                e_maddr = AW'(pa);
                e_mwe   = d_wr[w];
                if (d_wr[w]) begin
                    e_mwdata    = d_wdata[w*DW +: DW];
                    exp_mem[pa] = e_mwdata;
                end else begin
                    r.cyc = cyc + RL + 1; r.id = w; r.data = exp_mem[pa];
                    rq.push_back(r);
                end
                last_g = w;
            end else begin
                e_mwe = 1'b0;
            end
            if (d_ff) begin
                tmp = own[N-1];
                for (int i = N - 1; i >= 1; i--) own[i] = own[i-1];
                own[0] = tmp;
            end
        end
        cyc++;
    endtask

    task automatic idle();
        d_req = '0; d_wr = '0; d_ff = 1'b0;
    endtask

    int   gcnt [N];
    bit   pend [N];
    logic pwr [N];
    logic [AW-1:0] poff [N];
    logic [DW-1:0] pdat [N];

    initial begin
        reset = 1'b1; frame_flag = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0;
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = pat(AW'(a));
        d_rst = 1'b1; d_addr = '0; d_wdata = '0; idle();
        cycle(); cycle();
        d_rst = 1'b0;
        cycle();
        check("rst_buf_sel", 64'(buf_sel), 64'(8'b11_10_01_00));
        check("rst_rvalid", 64'(rvalid), 64'(0));

        // client 2 reads offset 5
        d_req = 4'b0100; d_addr[2*AW +: AW] = 19'd5;
        cycle();
        check("c2_grant", 64'(grant), 64'(4'b0100));
        idle(); cycle();
        check("c2_mem_addr", 64'(mem_addr), 64'(153605));
        check("c2_mem_we", 64'(mem_we), 64'(0));
        cycle(); cycle(); cycle();
        check("c2_rvalid", 64'(rvalid), 64'(4'b0100));
        check("c2_rdata", 64'(rdata), 64'(pat(19'd153605)));

        // all four clients read every cycle
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            d_req = 4'b1111; d_wr = '0;
            for (int i = 0; i < N; i++) d_addr[i*AW +: AW] = AW'(i * 10 + k);
            cycle();
            for (int i = 0; i < N; i++) if (grant[i]) gcnt[i]++;
        end
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < N; i++) check("rr_share", 64'(gcnt[i]), 64'(2));
`else
        check("fp_c0_count", 64'(gcnt[0]), 64'(8));
        check("fp_others", 64'(gcnt[1] + gcnt[2] + gcnt[3]), 64'(0));
`endif
        idle();
        for (int k = 0; k < RL + 2; k++) cycle();

        // client 1 then client 3 back-to-back reads
        d_req = 4'b0010; d_addr[1*AW +: AW] = 19'd7; cycle();
        d_req = 4'b1000; d_addr[3*AW +: AW] = 19'd9; cycle();
        idle(); cycle(); cycle(); cycle();
        check("b2b_rvalid1", 64'(rvalid), 64'(4'b0010));
        check("b2b_rdata1", 64'(rdata), 64'(pat(19'd76807)));
        cycle();
        check("b2b_rvalid3", 64'(rvalid), 64'(4'b1000));
        check("b2b_rdata3", 64'(rdata), 64'(pat(19'd230409)));

        // rotate once, then client 0 write lands in buffer 3
        d_ff = 1'b1; cycle();
        idle(); cycle();
        check("rot_buf_sel", 64'(buf_sel), 64'(8'b10_01_00_11));
        d_req = 4'b0001; d_wr = 4'b0001; d_addr[0 +: AW] = 19'd0; d_wdata[0 +: DW] = 36'h9ABCD1234;
        cycle();
        idle(); cycle();
        check("rot_wr_addr", 64'(mem_addr), 64'(230400));
        check("rot_wr_we", 64'(mem_we), 64'(1));
        check("rot_wr_data", 64'(mem_wdata), 64'(36'h9ABCD1234));

        // read granted in the same cycle as frame_flag uses the old mapping
        d_rst = 1'b1; cycle(); d_rst = 1'b0;
        d_req = 4'b0001; d_addr[0 +: AW] = 19'd11; d_ff = 1'b1; cycle();
        idle(); cycle();
        check("ff_rd_addr", 64'(mem_addr), 64'(11));
        check("ff_buf_sel", 64'(buf_sel), 64'(8'b10_01_00_11));
        cycle(); cycle(); cycle();
        check("ff_rvalid", 64'(rvalid), 64'(4'b0001));

        // reset while a read is in flight drops the tag
        d_req = 4'b1000; d_addr[3*AW +: AW] = 19'd20; cycle();
        idle(); cycle();
        d_rst = 1'b1; cycle();
        d_rst = 1'b0; cycle(); cycle();
        check("rst_fl_rvalid", 64'(rvalid), 64'(0));
        check("rst_fl_rdata", 64'(rdata), 64'(0));
        check("rst_fl_addr", 64'(mem_addr), 64'(0));
        check("rst_fl_bufsel", 64'(buf_sel), 64'(8'b11_10_01_00));

        // random traffic
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1) == 0) begin
                    pend[i] = 1'b1;
                    pwr[i]  = 1'($urandom_range(1));
                    poff[i] = ($urandom_range(7) == 0) ? AW'($urandom) : AW'($urandom_range(IL - 1));
                    pdat[i] = DW'({$urandom, $urandom});
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
                d_req[i] = pend[i];
                d_wr[i]  = pwr[i];
                d_addr[i*AW +: AW]  = poff[i];
                d_wdata[i*DW +: DW] = pdat[i];
            end
            d_ff  = ($urandom_range(7) == 0);
            d_rst = ($urandom_range(99) == 0);
            cycle();
            if (last_win >= 0) pend[last_win] = 1'b0;
        end
        d_rst = 1'b0; idle();
        for (int k = 0; k < RL + 2; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
